// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
//   - SZ_* access-size encodings carried on req_size
//   - state_e: request FSM states
//   - lane_en(): 4-bit byte write enable from size and addr[1:0]
//   - misaligned(): alignment / illegal-size check
//   - load_ext(): right-justify the addressed lanes and sign/zero extend
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << lane;
      SZ_HALF: lane_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  // Size 11 is folded in here so the top sees a single "bad shape" flag.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_HALF: load_ext = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
//   req_valid/req_ready : request handshake
//   req_write, req_size, req_signed, req_addr, req_wdata : request payload
//   rsp_valid, rsp_rdata, rsp_err : one-cycle response
interface data_mem_bytelane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lane_ram.sv
// DEPTH_WORDS x 32 storage split into four independent byte lanes.
//   i_clk   : clock
//   i_rd_en : capture the addressed word into o_rdata at this edge
//   i_we    : per-lane write enable
//   i_idx   : word index
//   i_wdata : lane-aligned write data
//   o_rdata : registered read data, held until the next i_rd_en
// No reset: contents are undefined until written.
module data_mem_lane_ram #(
  parameter int DEPTH_WORDS = 16384,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rd_en,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_we[l])  r_mem[i_idx] <= i_wdata[8*l +: 8];
      if (i_rd_en)  r_q          <= r_mem[i_idx];
    end

    assign o_rdata[8*l +: 8] = r_q;
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte/halfword/word data memory with valid/ready request, fixed read latency
// and range/alignment checking.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of data_mem_bytelane_if
// Stores commit at the accept edge; loads read at the accept edge and the
// RAM output register holds the word until the response cycle, where it is
// lane-extracted using the latched size/lane/signed fields.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int BASE_ADDR   = 1024,
  parameter int LATENCY     = 1      // 1..4
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_bytelane_if.slave  bus
);

  localparam int     IDX_W   = $clog2(DEPTH_WORDS);
  localparam longint LIMIT_L = longint'(BASE_ADDR) + 64'd4 * longint'(DEPTH_WORDS);
  // One extra bit so the upper bound cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] ADDR_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] ADDR_HI = (ADDR_W+1)'(LIMIT_L);

  state_e r_state, w_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic       r_req_ready, r_rsp_valid;
  logic       r_write, r_err, r_signed;
  logic [1:0] r_size, r_lane;

  logic              w_accept, w_err;
  logic [1:0]        w_lane;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_we;
  logic [DATA_W-1:0] w_wdata, w_ram_q;

  // ---------------- request decode ----------------
  assign w_accept = r_req_ready & bus.req_valid;
  assign w_lane   = bus.req_addr[1:0];
  assign w_err    = ({1'b0, bus.req_addr} < ADDR_LO) ||
                    ({1'b0, bus.req_addr} >= ADDR_HI) ||
                    misaligned(bus.req_size, w_lane);
  assign w_off    = bus.req_addr - ADDR_W'(BASE_ADDR);
  assign w_idx    = IDX_W'(w_off >> 2);
  assign w_we     = (w_accept & bus.req_write & ~w_err) ? lane_en(bus.req_size, w_lane) : 4'b0000;

  // Replicate right-justified store data across lanes; w_we picks the right copy.
  always_comb begin
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      SZ_BYTE: w_wdata = {4{bus.req_wdata[7:0]}};
      SZ_HALF: w_wdata = {2{bus.req_wdata[15:0]}};
      default: w_wdata = bus.req_wdata;
    endcase
  end

  data_mem_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .i_clk   (clk),
    .i_rd_en (w_accept & ~bus.req_write & ~w_err),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  // ---------------- FSM ----------------
  // Counter holds the remaining WAIT cycles; RESP is entered on the edge where
  // it would decrement to zero, giving LATENCY cycles from accept to response.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        w_cnt_nxt = 2'(LATENCY - 1);
        w_nxt     = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_nxt = RESP;
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= SZ_BYTE;
      r_lane      <= 2'd0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_nxt == IDLE);
      r_rsp_valid <= (w_nxt == RESP);
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_err    <= w_err;
        r_signed <= bus.req_signed;
        r_size   <= bus.req_size;
        r_lane   <= w_lane;
      end
    end
  end

  // ---------------- response ----------------
  // Driven only from registers (FSM, latched fields, RAM output register).
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_valid & r_err;
  assign bus.rsp_rdata = (r_rsp_valid & ~r_write & ~r_err) ?
                         load_ext(w_ram_q, r_size, r_lane, r_signed) : '0;

endmodule

// File: doc/data_mem_bytelane.md
# data_mem_bytelane

Parametrised data memory for the ARM datapath. It supports byte, halfword and word accesses with little-endian byte lanes and sign or zero extension on loads. A valid/ready request handshake and a configurable read latency let it model wait states. Address range and alignment are checked, and a violation is flagged on the response without corrupting memory. It sits between the MEM stage and the pipeline's stall logic and replaces the flat word-only data memory.

## Interface
- `DATA_W`, 32: data width; fixed at 32, four byte lanes.
- `ADDR_W`, 32: byte-address width.
- `DEPTH_WORDS`, 16384: number of 32-bit words stored.
- `BASE_ADDR`, 1024: byte address of word 0; must be a multiple of 4.
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- `req_signed` input 1: sign-extend byte/halfword loads; ignored on stores and word loads.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input DATA_W: store data, right-justified (byte in [7:0], halfword in [15:0]).
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output DATA_W: load result; 0 for stores and errors.
- `rsp_err` output 1: range, alignment or size error for this response.

## Operation
- FSM states: IDLE, WAIT, RESP. At most one request is outstanding.
- IDLE:
  - `req_ready`=1.
  - `req_valid`=1 accepts the request at the edge: it is latched and the counter is loaded with LATENCY-1.
  - Next state is WAIT if LATENCY>1, else RESP.
- WAIT: `req_ready`=0. The counter decrements each cycle; at 0 the FSM goes to RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle with the latched result, then the FSM returns to IDLE.
  - `req_ready`=0 in RESP, so back-to-back throughput is one request per LATENCY+1 cycles.
- Word index is (addr - BASE_ADDR) >> 2; lane is addr[1:0].
- Error conditions (any one sets `rsp_err`=1):
  - addr < BASE_ADDR;
  - addr >= BASE_ADDR + 4*DEPTH_WORDS;
  - halfword access with addr[0]=1;
  - word access with addr[1:0] != 0;
  - `req_size`=11.
- Stores:
  - Commit at the acceptance edge, writing only the addressed lanes: one byte, two lanes for a halfword, or all four for a word.
  - Errored stores write nothing.
- Loads:
  - The memory is read at the acceptance edge and the result is held until RESP.
  - The addressed lanes are right-justified; the upper bits are filled with 0, or with the lane's MSB if `req_signed`=1.
  - An errored load returns `rsp_rdata`=0.
- Memory contents are not reset and are undefined until written; the bench preloads the array via hierarchical init.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- Request accepted at edge T gives `rsp_valid` high during cycle T+LATENCY.
- The earliest next acceptance is edge T+LATENCY+1.
- A load issued in the cycle after a store accept to the same word sees the stored data; no bypass is needed because the store commits at its accept edge.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE immediately and no response is produced.
  - A store already accepted remains committed.
- `req_*` inputs are ignored whenever `req_ready`=0.
- All outputs are registered; there is no combinational path from `req_*` to `rsp_*`.

## Structure
- Shared package `dmem_pkg`:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - function computing the 4-bit lane enable from size and addr[1:0];
  - function for load extraction and extension.
- Sub-module `data_mem_lane_ram`: DEPTH_WORDS x 32 array with 4-bit byte write enable and synchronous read. It contains no reset logic.
- Top level holds the FSM, latency counter, address/alignment checker and response registers.

## Test plan
- LATENCY=1: store word 0xDEADBEEF to 1024, then load word from 1024 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` exactly 1 cycle after accept.
- Byte lanes: after the above, store byte 0x11 to 1025 -> word at 1024 reads 0xDEAD11EF. Signed byte load at 1027 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Halfword: signed load at 1026 -> 0xFFFFDEAD. Halfword load at 1025 -> `rsp_err`=1, `rsp_rdata`=0, memory unchanged.
- Range:
  - load at 1020 -> `rsp_err`=1;
  - store to BASE_ADDR+4*DEPTH_WORDS -> `rsp_err`=1 and no lane written;
  - load of last word (1024+4*(DEPTH_WORDS-1)) -> `rsp_err`=0.
- LATENCY=3: `req_valid` held high continuously -> accepts every 4 cycles; `req_ready` low for 3 cycles after each accept; `rsp_valid` 3 cycles after each accept.
- Reset in WAIT with LATENCY=3 (store to 1028 of 0x5) -> no `rsp_valid`, `req_ready`=1 asynchronously; a subsequent load of 1028 returns 0x5.
